// File: rtl/poly_horner_ctrl.sv
// Horner-method polynomial evaluator driving a 1-cycle-latency coefficient read port.
// Define POLY_OVF_DETECT_EN to report arithmetic overflow; otherwise overflow is constant 0.
module poly_horner_ctrl #(
    parameter int DATA_W = 32,
    parameter int N_COEF = 4,
    parameter int IDX_W  = $clog2(N_COEF)
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] x_in,
    output logic [IDX_W-1:0]  coef_idx,
    input  logic [DATA_W-1:0] coef_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    typedef enum logic [2:0] {IDLE, FETCH, INIT, STEP, DONE} state_t;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_COEF - 1);
    localparam logic [IDX_W-1:0] IDX_SECOND = IDX_W'(N_COEF - 2);

    state_t            state, state_next;
    logic [DATA_W-1:0] x_r;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  idx_dec;
    logic              aborting;
    logic              last_step;

    assign aborting  = abort && (state == FETCH || state == INIT || state == STEP);
    assign last_step = (state == STEP) && (k == '0) && !abort;
    // Address saturates at 0 so the final STEP and DONE present coefficient 0.
    assign idx_dec   = (coef_idx == '0) ? '0 : coef_idx - IDX_W'(1);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef POLY_OVF_DETECT_EN
    logic [2*DATA_W-1:0] product;
    logic [DATA_W:0]     sum;
    logic                step_ovf;
    logic                ovf_acc;

    assign product  = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, x_r};
    assign sum      = {1'b0, product[DATA_W-1:0]} + {1'b0, coef_data};
    assign acc_next = sum[DATA_W-1:0];
    assign step_ovf = (product[2*DATA_W-1:DATA_W] != '0) | sum[DATA_W];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ovf_acc  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                ovf_acc <= 1'b0;
            end else if (state == STEP && !abort) begin
                ovf_acc <= ovf_acc | step_ovf;
            end
            if (last_step) begin
                overflow <= ovf_acc | step_ovf;
            end
        end
    end
`else
    assign acc_next = acc * x_r + coef_data;
    assign overflow = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = abort ? IDLE : INIT;
            INIT:    state_next = abort ? IDLE : STEP;
            STEP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (k == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            x_r      <= '0;
            acc      <= '0;
            k        <= '0;
            coef_idx <= '0;
            result   <= '0;
        end else if (aborting) begin
            coef_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r      <= x_in;
                        coef_idx <= IDX_LAST;
                    end
                end
                FETCH: coef_idx <= IDX_SECOND;
                INIT: begin
                    acc      <= coef_data;
                    k        <= IDX_SECOND;
                    coef_idx <= idx_dec;
                end
                STEP: begin
                    acc <= acc_next;
                    if (k == '0) begin
                        result   <= acc_next;
                        coef_idx <= '0;
                    end else begin
                        k        <= k - IDX_W'(1);
                        coef_idx <= idx_dec;
                    end
                end
                default: coef_idx <= '0;
            endcase
        end
    end

endmodule
